ysyx_25030093_lsu_ctrl: RTL

Multi-cycle load/store sequencer for the NPC core. It takes one memory operation per request from the execute stage: LB, LH, LW, LBU, LHU, SB, SH or SW. It computes and checks the effective address, then drives a valid/ready memory request channel and waits for the response. Load data is lane-extracted and sign- or zero-extended before a one-cycle writeback pulse. This replaces the combinational memory access inside the ALU, so the ALU keeps only arithmetic, compare and branch functions.

---
 rtl/ysyx_25030093_lsu_pkg.sv | 50 +++++
 rtl/ysyx_25030093_lsu_align.sv | 53 +++++
 rtl/ysyx_25030093_lsu_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ysyx_25030093_lsu_pkg.sv
// rtl/ysyx_25030093_lsu_pkg.sv - op encoding, FSM states and size helpers for the LSU sequencer
package ysyx_25030093_lsu_pkg;

    // Memory operation kinds as presented by the execute stage
    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_kind_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // True for the five load kinds
    function automatic logic is_load(input op_kind_e k);
        logic r;
        case (k)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    // Access size in bytes: 1, 2 or 4
    function automatic logic [2:0] op_size(input op_kind_e k);
        logic [2:0] r;
        case (k)
            OP_LB, OP_LBU, OP_SB: r = 3'd1;
            OP_LH, OP_LHU, OP_SH: r = 3'd2;
            default:              r = 3'd4;
        endcase
        return r;
    endfunction

    // Loads whose result is sign-extended from the top bit of the lane
    function automatic logic is_signed_ld(input op_kind_e k);
        return (k == OP_LB) || (k == OP_LH);
    endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_align.sv
// rtl/ysyx_25030093_lsu_align.sv - byte-lane steering for stores and lane extraction for loads
module ysyx_25030093_lsu_align
    import ysyx_25030093_lsu_pkg::*;
(
    input  logic [1:0]  ea_lo_i,
    input  op_kind_e    op_kind_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_sh_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [4:0]  lane_shift;
    logic [31:0] lane;
    logic [2:0]  size;
    logic        load;
    logic        sext;
    logic [3:0]  strb_base;

    assign lane_shift = {ea_lo_i, 3'b000};
    assign lane       = rdata_i >> lane_shift;
    assign size       = op_size(op_kind_i);
    assign load       = is_load(op_kind_i);
    assign sext       = is_signed_ld(op_kind_i);

    // Alignment check, store strobe/data placement and load extension
    always_comb begin
        misalign_o  = 1'b0;
        strb_base   = 4'b1111;
        load_data_o = lane;
        case (size)
            3'd1: begin
                strb_base   = 4'b0001;
                load_data_o = {{24{sext & lane[7]}}, lane[7:0]};
            end
            3'd2: begin
                misalign_o  = ea_lo_i[0];
                strb_base   = 4'b0011;
                load_data_o = {{16{sext & lane[15]}}, lane[15:0]};
            end
            default: begin
                misalign_o  = |ea_lo_i;
                strb_base   = 4'b1111;
                load_data_o = lane;
            end
        endcase
        wstrb_o    = load ? 4'b0000 : (strb_base << ea_lo_i);
        wdata_sh_o = load ? 32'd0 : (wdata_i << lane_shift);
    end

endmodule

// File: rtl/ysyx_25030093_lsu_ctrl.sv
// rtl/ysyx_25030093_lsu_ctrl.sv - multi-cycle load/store sequencer with request/response memory port
module ysyx_25030093_lsu_ctrl
    import ysyx_25030093_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_kind,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    op_kind_e          kind_q;
    logic [1:0]        ea_lo_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              req_valid_q;
    logic [31:0]       req_addr_q;
    logic              req_wen_q;
    logic [31:0]       req_wdata_q;
    logic [3:0]        req_wstrb_q;

    logic              wb_valid_q;
    logic [31:0]       wb_data_q;
    logic              wb_err_q;

    logic [31:0]       ea;
    op_kind_e          kind_in;
    logic [1:0]        al_ea_lo;
    op_kind_e          al_kind;
    logic [31:0]       al_wdata;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_load;
    logic              al_misalign;

    assign ea      = base + offset;
    assign kind_in = op_kind_e'(op_kind);

    // In IDLE the aligner sees the incoming op; afterwards it sees the captured one
    assign al_ea_lo = (state_q == ST_IDLE) ? ea[1:0] : ea_lo_q;
    assign al_kind  = (state_q == ST_IDLE) ? kind_in : kind_q;

    ysyx_25030093_lsu_align u_align (
        .ea_lo_i     (al_ea_lo),
        .op_kind_i   (al_kind),
        .wdata_i     (wdata),
        .rdata_i     (mem_resp_rdata),
        .wdata_sh_o  (al_wdata),
        .wstrb_o     (al_wstrb),
        .load_data_o (al_load),
        .misalign_o  (al_misalign)
    );

    // Sequencer FSM with registered request and writeback outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= OP_LB;
            ea_lo_q     <= 2'b00;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= 32'd0;
            req_wstrb_q <= 4'b0000;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 32'd0;
            wb_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wb_valid_q <= 1'b0;
                    if (op_valid) begin
                        kind_q  <= kind_in;
                        ea_lo_q <= ea[1:0];
                        cnt_q   <= '0;
                        if (al_misalign) begin
                            // Misaligned ops never reach the bus
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            wb_err_q   <= 1'b1;
                            wb_data_q  <= 32'd0;
                        end else begin
                            state_q     <= ST_REQ;
                            req_valid_q <= 1'b1;
                            req_addr_q  <= {ea[31:2], 2'b00};
                            req_wen_q   <= ~is_load(kind_in);
                            req_wdata_q <= al_wdata;
                            req_wstrb_q <= al_wstrb;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state_q    <= ST_DONE;
                        wb_valid_q <= 1'b1;
                        wb_err_q   <= mem_resp_err;
                        wb_data_q  <= (mem_resp_err || !is_load(kind_q)) ? 32'd0 : al_load;
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        state_q    <= ST_DONE;
                        wb_valid_q <= 1'b1;
                        wb_err_q   <= 1'b1;
                        wb_data_q  <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: the completion pulse lasts exactly one cycle
                    state_q    <= ST_IDLE;
                    wb_valid_q <= 1'b0;
                    wb_err_q   <= 1'b0;
                    wb_data_q  <= 32'd0;
                end
            endcase
        end
    end

    assign op_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wstrb = req_wstrb_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_err        = wb_err_q;

endmodule
